// File: rtl/fifo_rd_packer_if.sv
// Read-side bundle for fifo_rd_packer: FIFO read port,
// flush pulse and the packed-word valid/ready output.
interface fifo_rd_packer_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
);
  localparam int OSIZE = DSIZE * RATIO;
  localparam int CW    = $clog2(RATIO) + 1;

  logic             empty;
  logic             rreq;
  logic [DSIZE-1:0] rdata;
  logic             flush;
  logic [OSIZE-1:0] out_data;
  logic [CW-1:0]    out_bytes;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output empty, rdata, flush, out_ready,
    input  rreq, out_data, out_bytes,
    input  out_valid, busy
  );

  modport slave (
    input  empty, rdata, flush, out_ready,
    output rreq, out_data, out_bytes,
    output out_valid, busy
  );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs RATIO consecutive FIFO entries into one wide word,
// with flush of partial words and valid/ready output.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input logic             rclk,
  input logic             rst,
  fifo_rd_packer_if.slave bus
);
  localparam int OSIZE = DSIZE * RATIO;
  localparam int CW    = $clog2(RATIO) + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  localparam cnt_t FULL = cnt_t'(RATIO);
  localparam cnt_t LAST = cnt_t'(RATIO - 1);

  logic [DSIZE-1:0] lane_q [RATIO];
  logic [DSIZE-1:0] lane_d [RATIO];
  cnt_t             cnt_q, cnt_d;
  logic             pend_q;
  logic             flush_q, flush_d;
  logic             ov_q, ov_d;
  logic [OSIZE-1:0] od_q, od_d;
  cnt_t             ob_q, ob_d;

  logic             out_free;
  logic             rreq;
  sum_t             inflight;
  logic [OSIZE-1:0] full_w;
  logic [OSIZE-1:0] part_w;
  logic [OSIZE-1:0] cap_w;

  assign out_free = !ov_q || bus.out_ready;
  assign inflight = sum_t'(cnt_q) + sum_t'(pend_q);
  assign rreq     = !rst && !bus.empty && !flush_q
                  && (inflight < sum_t'(RATIO));

  // Partial word keeps only the captured lanes; upper ones read zero
  always_comb begin
    full_w = '0;
    part_w = '0;
    for (int i = 0; i < RATIO; i++) begin
      full_w[i*DSIZE +: DSIZE] = lane_q[i];
      if (cnt_t'(i) < cnt_q)
        part_w[i*DSIZE +: DSIZE] = lane_q[i];
    end
  end

  assign cap_w = {bus.rdata, full_w[OSIZE-DSIZE-1:0]};

  always_comb begin
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ob_d    = ob_q;
    if (ov_q && bus.out_ready)
      ov_d = 1'b0;
    if (pend_q) begin
      lane_d[cnt_q[CW-2:0]] = bus.rdata;
      if (cnt_q == LAST && out_free) begin
        od_d  = cap_w;
        ob_d  = FULL;
        ov_d  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end else if (cnt_q == FULL) begin
      if (out_free) begin
        od_d  = full_w;
        ob_d  = FULL;
        ov_d  = 1'b1;
        cnt_d = '0;
      end
    end else if (flush_q && out_free) begin
      if (cnt_q != '0) begin
        od_d  = part_w;
        ob_d  = cnt_q;
        ov_d  = 1'b1;
        cnt_d = '0;
      end
      flush_d = 1'b0;
    end
    if (bus.flush && !flush_q)
      flush_d = 1'b1;
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RATIO; i++)
        lane_q[i] <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      flush_q <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ob_q    <= '0;
    end else begin
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      pend_q  <= rreq;
      flush_q <= flush_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ob_q    <= ob_d;
    end
  end

  assign bus.rreq      = rreq;
  assign bus.out_data  = od_q;
  assign bus.out_bytes = ob_q;
  assign bus.out_valid = ov_q;
  assign bus.busy      = (cnt_q != '0) | pend_q
                       | flush_q | ov_q;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: FIFO model feeding the
// read port, scoreboard of expected packed words.
module tb_fifo_rd_packer;
  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int OSIZE = 32;
  localparam int CW    = 3;

  typedef logic [OSIZE+CW-1:0] word_t;

  logic rclk = 1'b0;
  logic rst  = 1'b1;

  always #5 rclk = ~rclk;

  fifo_rd_packer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) bus ();

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk (rclk),
    .rst  (rst),
    .bus  (bus)
  );

  logic [7:0] fifo [$];
  word_t      exp_q [$];
  int         acc_cyc [$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t_rq_first, t_rq_last, n_rq;
  int t_ov_first, n_ov;

  function automatic word_t w(logic [31:0] d,
                              logic [2:0] b);
    return {d, b};
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    t_rq_first = -1;
    t_rq_last  = -1;
    n_rq       = 0;
    t_ov_first = -1;
    n_ov       = 0;
    acc_cyc.delete();
  endtask

  task automatic push(logic [7:0] b);
    fifo.push_back(b);
    bus.empty = 1'b0;
  endtask

  // One clock: sample outputs at negedge, then model the FIFO
  task automatic tick();
    logic  fire;
    logic  acc;
    word_t got;
    word_t want;
    @(negedge rclk);
    fire = bus.rreq && !bus.empty;
    acc  = bus.out_valid && bus.out_ready;
    if (bus.rreq) begin
      if (t_rq_first < 0) t_rq_first = cyc;
      t_rq_last = cyc;
      n_rq++;
    end
    if (bus.out_valid) begin
      if (t_ov_first < 0) t_ov_first = cyc;
      n_ov++;
    end
    if (acc) begin
      got = {bus.out_data, bus.out_bytes};
      acc_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        want = exp_q.pop_front();
        chk("word", 64'(got), 64'(want));
      end
    end
    @(posedge rclk);
    #1;
    cyc++;
    if (fire) bus.rdata = fifo.pop_front();
    bus.empty = (fifo.size() == 0);
  endtask

  task automatic drain(int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.empty     = 1'b1;
    bus.rdata     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    clr_stats();
    rst = 1'b1;
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_rreq",  64'(bus.rreq), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  64'(bus.out_data), 64'd0);
    chk("rst_bytes", 64'(bus.out_bytes), 64'd0);
    chk("rst_busy",  64'(bus.busy), 64'd0);
    rst = 1'b0;

    // full packing
    bus.out_ready = 1'b1;
    clr_stats();
    push(8'h11); push(8'h22);
    push(8'h33); push(8'h44);
    exp_q.push_back(w(32'h44332211, 3'd4));
    drain(20);
    chk("pack_latency",
        64'(t_ov_first - t_rq_first), 64'd5);
    chk("pack_rreq_cnt", 64'(n_rq), 64'd4);

    // streaming
    clr_stats();
    for (int i = 1; i <= 8; i++) push(8'(i));
    exp_q.push_back(w(32'h04030201, 3'd4));
    exp_q.push_back(w(32'h08070605, 3'd4));
    drain(40);
    chk("stream_acc_n", 64'(acc_cyc.size()), 64'd2);
    if (acc_cyc.size() == 2)
      chk("stream_gap",
          64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
    chk("stream_rreq_span",
        64'(t_rq_last - t_rq_first), 64'd8);
    chk("stream_rreq_cnt", 64'(n_rq), 64'd8);

    // backpressure
    bus.out_ready = 1'b0;
    clr_stats();
    for (int i = 0; i < 12; i++) push(8'(8'h21 + i));
    exp_q.push_back(w(32'h24232221, 3'd4));
    exp_q.push_back(w(32'h28272625, 3'd4));
    exp_q.push_back(w(32'h2c2b2a29, 3'd4));
    repeat (20) tick();
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_data", 64'(bus.out_data), 64'h24232221);
    chk("bp_bytes", 64'(bus.out_bytes), 64'd4);
    chk("bp_parked_rreq", 64'(bus.rreq), 64'd0);
    chk("bp_fifo_left", 64'(fifo.size()), 64'd4);
    chk("bp_no_accept", 64'(acc_cyc.size()), 64'd0);
    bus.out_ready = 1'b1;
    drain(40);
    chk("bp_fifo_drained", 64'(fifo.size()), 64'd0);

    // flush of a partial word
    clr_stats();
    push(8'hAA); push(8'hBB);
    repeat (4) tick();
    exp_q.push_back(w(32'h0000BBAA, 3'd2));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drain(10);
    chk("flush_busy", 64'(bus.busy), 64'd0);

    // flush with nothing packed
    clr_stats();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (3) tick();
    chk("flush0_no_out", 64'(n_ov), 64'd0);
    chk("flush0_busy", 64'(bus.busy), 64'd0);

    // flush while a full word is held
    bus.out_ready = 1'b0;
    clr_stats();
    for (int i = 0; i < 7; i++) push(8'(8'h31 + i));
    exp_q.push_back(w(32'h34333231, 3'd4));
    exp_q.push_back(w(32'h00373635, 3'd3));
    repeat (15) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (5) tick();
    chk("fbp_data", 64'(bus.out_data), 64'h34333231);
    chk("fbp_bytes", 64'(bus.out_bytes), 64'd4);
    chk("fbp_no_accept", 64'(acc_cyc.size()), 64'd0);
    bus.out_ready = 1'b1;
    drain(20);
    tick();
    chk("fbp_busy", 64'(bus.busy), 64'd0);

    // reset mid-word
    bus.out_ready = 1'b0;
    clr_stats();
    for (int i = 0; i < 6; i++) push(8'(8'h41 + i));
    exp_q.push_back(w(32'h44434241, 3'd4));
    repeat (12) tick();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_rreq", 64'(bus.rreq), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    clr_stats();
    push(8'h51); push(8'h52);
    push(8'h53); push(8'h54);
    exp_q.push_back(w(32'h54535251, 3'd4));
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, in the read clock domain. Pulls DSIZE-bit entries from the FIFO's read port (rreq/empty/rdata) and packs RATIO consecutive entries into one wide word. The wide word is offered downstream on a valid/ready handshake. A flush input forces out a partial word at packet end.

## Interface
- DSIZE, 8, width of one FIFO entry (lane).
- RATIO, 4, lanes per output word (power of two, ≥2); OSIZE = DSIZE*RATIO.
- CW, derived = clog2(RATIO)+1, width of lane counts.

- rclk  in  1  read-side clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- empty  in  1  FIFO empty flag.
- rreq  out  1  FIFO read request (combinational).
- rdata  in  DSIZE  FIFO read data, valid the cycle after rreq && !empty.
- flush  in  1  single-cycle pulse: emit the partial word.
- out_data  out  OSIZE  packed word; lane 0 (first byte read) in bits [DSIZE-1:0].
- out_bytes  out  CW  number of valid lanes in out_data (1..RATIO).
- out_valid  out  1  out_data/out_bytes valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- busy  out  1  cnt!=0 | pend | flush_req | out_valid.

## Operation
- State: lane register array lane[0..RATIO-1]; cnt (0..RATIO); pend (read issued last cycle); flush_req; output register (out_data, out_bytes, out_valid).
- out_free = !out_valid || out_ready.
- rreq = !rst && !empty && !flush_req && (cnt + pend < RATIO).
- pend <= rreq (the FIFO ignores rreq while empty; rreq is already gated by empty).
- Capture: if pend, lane[cnt] <= rdata.
  - If cnt == RATIO-1 and out_free: load out_data = {rdata, lane[RATIO-2..0]}, out_bytes = RATIO, out_valid = 1, cnt <= 0.
  - Else: cnt <= cnt+1. If that reaches RATIO, the word is parked.
- Parked word: when cnt == RATIO and out_free, load the output register with out_bytes = RATIO, then cnt <= 0.
- Flush: a flush pulse sets flush_req, and further rreq are blocked.
  - Once pend == 0 and out_free: if 0 < cnt < RATIO, load out_data = the captured lanes with unused upper lanes zero, out_bytes = cnt, cnt <= 0, and clear flush_req.
  - If cnt == 0, clear flush_req with no output.
  - If cnt == RATIO, emit the full word first (as a parked word); flush_req then clears on the next eligible cycle with cnt == 0.
- flush while flush_req is already set has no additional effect.
- Handshake: out_valid stays high and out_data/out_bytes stay stable until accepted. On acceptance with no new load that cycle, out_valid <= 0.
- A load and an acceptance in the same cycle produce back-to-back words with out_valid held high.

## Timing
- Reset values: rreq 0, out_valid 0, out_data 0, out_bytes 0, busy 0. Internal cnt 0, pend 0, flush_req 0, lanes 0.
- Reset asserted mid-operation clears all state immediately. In-flight and partially packed entries are discarded; there is no recovery.
- Latency: first rreq in cycle 0 with no stalls → out_valid high in cycle RATIO+1 (cycle 5 for RATIO=4).
- Steady-state throughput: one word per RATIO+1 cycles. rreq is high for RATIO cycles, then low for 1 cycle while the last entry is in flight.
- Backpressure: with out_valid held, packing of the next word continues up to cnt == RATIO and then stalls (rreq low). Nothing is lost or overwritten.
- Flush latency: ≤2 cycles after pend drains, given out_free.
- empty rising while pend = 1: the pending capture still completes.

## Test plan
- Reset: assert rst mid-word (cnt=2, out_valid=1) → next cycle out_valid=0, rreq=0, busy=0; after release, the next 4 bytes form a fresh word.
- Full packing: FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 → rreq cycles 0–3; out_valid in cycle 5 with out_data=0x44332211, out_bytes=4.
- Streaming: 8 bytes 0x01..0x08 → words 0x04030201 then 0x08070605, 5 cycles apart; rreq low exactly 1 cycle between bursts.
- Backpressure: out_ready=0 for 20 cycles with 12 bytes available → first word held stable; second word parked (cnt=4, rreq=0). On out_ready=1, the words are emitted in order with no loss.
- Flush partial: bytes 0xAA,0xBB then flush → out_data=0x0000BBAA, out_bytes=2; flush with cnt=0 → no output, busy drops.
- Flush during backpressure: flush with cnt=3 while out_valid held → partial word emitted only after acceptance of the held word, with out_bytes=3.
